// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface bundle; disabled sideband fields are still declared
// so that every endpoint sees the same signal set.
interface taxi_axis_if #(
   parameter int DATA_W  = 8,
   parameter bit KEEP_EN = (DATA_W > 8),
   parameter int KEEP_W  = (DATA_W + 7) / 8,
   parameter bit STRB_EN = 1'b0,
   parameter bit LAST_EN = 1'b1,
   parameter bit ID_EN   = 1'b0,
   parameter int ID_W    = 8,
   parameter bit DEST_EN = 1'b0,
   parameter int DEST_W  = 8,
   parameter bit USER_EN = 1'b0,
   parameter int USER_W  = 1
) ();
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic [KEEP_W-1:0] tstrb;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [ID_W-1:0]   tid;
   logic [DEST_W-1:0] tdest;
   logic [USER_W-1:0] tuser;

   modport src (
      output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
      input  tready
   );

   modport snk (
      input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/taxi_axis_broadcast_mask.sv
// AXI4-Stream 1:M_COUNT broadcast with a per-frame output-select mask.
// Define TAXI_AXIS_BCAST_STATS_EN to add the forwarded/dropped frame counters.
module taxi_axis_broadcast_mask #(
   parameter int M_COUNT = 4,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   taxi_axis_if.snk           s_axis,
   taxi_axis_if.src           m_axis [M_COUNT-1:0],
   input  logic [M_COUNT-1:0] s_mask
`ifdef TAXI_AXIS_BCAST_STATS_EN
   ,
   output logic [CNT_W-1:0]   stat_frames,
   output logic [CNT_W-1:0]   stat_drops
`endif
);
   localparam int DATA_W  = s_axis.DATA_W;
   localparam bit KEEP_EN = s_axis.KEEP_EN && m_axis[0].KEEP_EN;
   localparam int KEEP_W  = s_axis.KEEP_W;
   localparam bit STRB_EN = s_axis.STRB_EN && m_axis[0].STRB_EN;
   localparam bit LAST_EN = s_axis.LAST_EN && m_axis[0].LAST_EN;
   localparam bit ID_EN   = s_axis.ID_EN && m_axis[0].ID_EN;
   localparam int ID_W    = s_axis.ID_W;
   localparam bit DEST_EN = s_axis.DEST_EN && m_axis[0].DEST_EN;
   localparam int DEST_W  = s_axis.DEST_W;
   localparam bit USER_EN = s_axis.USER_EN && m_axis[0].USER_EN;
   localparam int USER_W  = s_axis.USER_W;

   if (M_COUNT < 1 || M_COUNT > 16)
      $fatal(0, "Error: M_COUNT out of range 1-16 (instance %m)");

   for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_param_chk
      if (m_axis[gi].DATA_W != DATA_W)
         $fatal(0, "Error: m_axis/s_axis DATA_W mismatch (instance %m)");
      if (KEEP_EN && m_axis[gi].KEEP_W != KEEP_W)
         $fatal(0, "Error: m_axis/s_axis KEEP_W mismatch (instance %m)");
   end

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic [KEEP_W-1:0] strb;
      logic              last;
      logic [ID_W-1:0]   id;
      logic [DEST_W-1:0] dest;
      logic [USER_W-1:0] user;
   } beat_t;

   beat_t              in_beat;
   beat_t              out_q, out_d;
   beat_t              temp_q, temp_d;
   logic [M_COUNT-1:0] pending_q, pending_d;
   logic [M_COUNT-1:0] temp_mask_q, temp_mask_d;
   logic [M_COUNT-1:0] mask_q, mask_d;
   logic               temp_valid_q, temp_valid_d;
   logic               s_tready_q, s_tready_d;
   logic               frame_start_q, frame_start_d;

   logic [M_COUNT-1:0] m_tready;
   logic [M_COUNT-1:0] pend_left;
   logic [M_COUNT-1:0] beat_mask;
   logic               all_clear;
   logic               s_xfer;

   // Disabled fields are tied off here so the output registers carry legal values.
   always_comb begin
      in_beat.data = s_axis.tdata;
      in_beat.keep = KEEP_EN ? s_axis.tkeep : {KEEP_W{1'b1}};
      in_beat.strb = STRB_EN ? s_axis.tstrb : in_beat.keep;
      in_beat.last = LAST_EN ? s_axis.tlast : 1'b1;
      in_beat.id   = ID_EN   ? s_axis.tid   : {ID_W{1'b0}};
      in_beat.dest = DEST_EN ? s_axis.tdest : {DEST_W{1'b0}};
      in_beat.user = USER_EN ? s_axis.tuser : {USER_W{1'b0}};
   end

   always_comb begin
      pend_left = pending_q & ~m_tready;
      all_clear = (pend_left == '0);
      s_xfer    = s_axis.tvalid && s_tready_q;
      beat_mask = frame_start_q ? s_mask : mask_q;

      pending_d     = pend_left;
      temp_valid_d  = temp_valid_q;
      temp_mask_d   = temp_mask_q;
      out_d         = out_q;
      temp_d        = temp_q;
      mask_d        = mask_q;
      frame_start_d = frame_start_q;

      if (s_tready_q) begin
         if (all_clear) begin
            // A zero mask leaves no pending bits, so the beat is dropped here.
            pending_d = s_axis.tvalid ? beat_mask : '0;
            out_d     = in_beat;
         end else begin
            temp_valid_d = s_axis.tvalid;
            temp_mask_d  = beat_mask;
            temp_d       = in_beat;
         end
      end else if (all_clear) begin
         pending_d    = temp_valid_q ? temp_mask_q : '0;
         temp_valid_d = 1'b0;
         out_d        = temp_q;
      end

      s_tready_d = all_clear || (!temp_valid_q && (pending_q == '0 || !s_axis.tvalid));

      if (s_xfer) begin
         if (frame_start_q)
            mask_d = s_mask;
         frame_start_d = in_beat.last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_tready_q    <= 1'b0;
         pending_q     <= '0;
         temp_valid_q  <= 1'b0;
         temp_mask_q   <= '0;
         mask_q        <= '0;
         frame_start_q <= 1'b1;
      end else begin
         s_tready_q    <= s_tready_d;
         pending_q     <= pending_d;
         temp_valid_q  <= temp_valid_d;
         temp_mask_q   <= temp_mask_d;
         mask_q        <= mask_d;
         frame_start_q <= frame_start_d;
      end
   end

   always_ff @(posedge clk) begin
      out_q  <= out_d;
      temp_q <= temp_d;
   end

   assign s_axis.tready = s_tready_q;

   for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_out
      assign m_tready[gi]        = m_axis[gi].tready;
      assign m_axis[gi].tvalid   = pending_q[gi];
      assign m_axis[gi].tdata    = out_q.data;
      assign m_axis[gi].tkeep    = out_q.keep;
      assign m_axis[gi].tstrb    = out_q.strb;
      assign m_axis[gi].tlast    = out_q.last;
      assign m_axis[gi].tid      = out_q.id;
      assign m_axis[gi].tdest    = out_q.dest;
      assign m_axis[gi].tuser    = out_q.user;
   end

`ifdef TAXI_AXIS_BCAST_STATS_EN
   logic [CNT_W-1:0] frames_q, frames_d;
   logic [CNT_W-1:0] drops_q, drops_d;

   // Frames are counted as they enter, on the closing beat.
   always_comb begin
      frames_d = frames_q;
      drops_d  = drops_q;
      if (s_xfer && in_beat.last) begin
         if (beat_mask != '0)
            frames_d = frames_q + CNT_W'(1);
         else
            drops_d = drops_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_q <= '0;
         drops_q  <= '0;
      end else begin
         frames_q <= frames_d;
         drops_q  <= drops_d;
      end
   end

   assign stat_frames = frames_q;
   assign stat_drops  = drops_q;
`endif
endmodule

// File: doc/taxi_axis_broadcast_mask.md
TAXI_AXIS_BROADCAST_MASK -- requirements
Module: taxi_axis_broadcast_mask

Interface
REQ-001 The block SHALL have parameter M_COUNT, default 4, meaning number of AXI4-Stream outputs, legal range 1-16.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning width of each statistics counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port s_axis  taxi_axis_if.snk  interface  the input stream.
REQ-006 The block SHALL have port m_axis[M_COUNT-1:0]  taxi_axis_if.src  interface  the output streams.
REQ-007 The block SHALL have port s_mask  input  M_COUNT  the output-select mask, sampled on the first beat of each frame.
REQ-008 The block SHALL have port stat_frames  output  CNT_W  the count of frames forwarded (present only with TAXI_AXIS_BCAST_STATS_EN).
REQ-009 The block SHALL have port stat_drops  output  CNT_W  the count of frames dropped (present only with TAXI_AXIS_BCAST_STATS_EN).
REQ-010 The block SHALL fatal at elaboration on an m_axis/s_axis DATA_W mismatch, or on a KEEP_W mismatch when KEEP_EN is set.

Function
REQ-011 The block SHALL use one output register stage plus one skid (temp) register shared by all outputs.
- Latency is exactly 1 cycle from s_axis transfer to m_axis tvalid.
REQ-012 The block SHALL drive tdata, tkeep, tstrb, tlast, tid, tdest and tuser identically on all outputs.
- Disabled sideband fields are tied off: tkeep to all ones, tstrb to tkeep, tlast to 1, tid/tdest/tuser to 0.
REQ-013 The block SHALL keep one pending bit per output.
- A pending bit clears on the cycle that output's tready is high.
- Each output is released independently.
REQ-014 The block SHALL register a new beat into the output stage when no pending bit remains set after the current cycle's acceptances.
- Otherwise the beat goes to the temp register.
- The temp register drains to the output stage as soon as all pending bits clear.
REQ-015 The block SHALL register s_axis.tready and drive it high when either condition holds:
- all pending bits clear this cycle, or
- temp is empty and (the output stage is empty or s_axis.tvalid is low).
REQ-016 The block SHALL track a frame-start flag, which is 1 after reset and 1 after a beat with tlast=1.
- When LAST_EN is off, every beat is a frame.
REQ-017 The block SHALL latch s_mask on a frame-start beat and use that latched mask for every beat of the frame.
- Changes to s_mask mid-frame are ignored.
REQ-018 The block SHALL set pending bits to the latched mask for each beat; unselected outputs see tvalid low for the whole frame.
REQ-019 The block SHALL ignore tready on unselected outputs; their backpressure never stalls the input.
REQ-020 The block SHALL handle a zero latched mask as follows:
- Beats are accepted at full rate (tready high subject to REQ-015).
- Beats are discarded and the frame counts as one drop.
REQ-021 The block SHALL update the stage correctly when an input transfer and the final output acceptance occur in the same cycle.
- It loads the new beat with no bubble.
- Sustained throughput is 1 beat/cycle while all selected outputs hold tready high.
REQ-022 The block SHALL never reorder, duplicate or lose beats to a selected output.

Reset
REQ-023 The block SHALL, while rst_n is low, hold:
- s_axis.tready at 0,
- all m_axis tvalid at 0,
- temp valid at 0,
- all pending bits at 0,
- the frame-start flag at 1,
- stat_frames and stat_drops at 0.
REQ-024 The block SHALL assert s_axis.tready on the first rising clk edge after rst_n deasserts.
REQ-025 The block SHALL abandon any partial frame on reset mid-frame; the next accepted beat is a frame start.
REQ-026 The block SHALL NOT reset the data registers (tdata, tkeep, tstrb, tlast, tid, tdest, tuser).

Configuration
REQ-027 The block SHALL compile stat_frames and stat_drops in only when TAXI_AXIS_BCAST_STATS_EN is defined.
- stat_frames increments on the tlast beat of a frame with a nonzero mask.
- stat_drops increments on the tlast beat of a frame with a zero mask.
- Both counters wrap modulo 2^CNT_W.
- Without the macro, the ports and counters are absent and all other behaviour is identical.

Verification
REQ-028 With M_COUNT=4, s_mask=4'b1111, all tready=1 and a 16-beat frame: all outputs SHALL receive 16 beats back-to-back, with the first tvalid 1 cycle after the first transfer.
REQ-029 With s_mask=4'b0101 and m_axis[1].tready=0 permanently: outputs 0 and 2 SHALL receive the full frame with no stall, and outputs 1 and 3 SHALL keep tvalid at 0.
REQ-030 With s_mask=4'b1111 and m_axis[2].tready=0 for 5 cycles mid-frame: s_axis.tready SHALL drop within 2 cycles, the temp register SHALL hold one beat, and the frame SHALL complete intact on all outputs after release.
REQ-031 With s_mask changed from 4'b0011 to 4'b1100 on beat 3 of an 8-beat frame: all 8 beats SHALL go to outputs 0-1 only, and the next frame SHALL go to outputs 2-3.
REQ-032 With s_mask=0 on a 4-beat frame followed by a mask=4'b0001 frame: the first frame SHALL be consumed silently and the second delivered; with the macro defined, stat_drops=1 and stat_frames=1.
REQ-033 With rst_n pulsed low on beat 2 of a stalled frame: all tvalid SHALL go to 0 immediately (asynchronous), and the next beat after release SHALL be treated as a frame start with s_mask re-sampled.
